// File: rtl/fp_comparator.sv
// Registered binary32 ordering comparator: greater/equal/less one clock after in_valid.
// Optional macro FP_CMP_UNORDERED_EN adds a registered 'unordered' (NaN seen) output.
module fp_comparator (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        in_valid,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic        out_valid,
  output logic        greater,
  output logic        equal,
`ifdef FP_CMP_UNORDERED_EN
  output logic        unordered,
`endif
  output logic        less
);

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Returns {gt, eq, lt}; all zero when either operand is NaN.
  function automatic logic [2:0] order(input logic [31:0] a, input logic [31:0] b);
    logic [2:0] res;
    res = 3'b000;
    if (is_nan(a) || is_nan(b)) begin
      res = 3'b000;
    end else if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
      res = 3'b010;
    end else if (a[31] != b[31]) begin
      res = a[31] ? 3'b001 : 3'b100;
    end else if (a[30:0] == b[30:0]) begin
      res = 3'b010;
    end else if ((a[30:0] > b[30:0]) ^ a[31]) begin
      res = 3'b100;
    end else begin
      res = 3'b001;
    end
    return res;
  endfunction

  logic [2:0] ord_p0;
  logic       nan_p0;

  assign ord_p0 = order(a_operand, b_operand);
  assign nan_p0 = is_nan(a_operand) || is_nan(b_operand);

  // Stage p0 -> p1: flags load only on accepted operands and hold otherwise.
  logic       vld_p1;
  logic       gt_p1;
  logic       eq_p1;
  logic       lt_p1;
  logic       un_p1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_p1 <= 1'b0;
      gt_p1  <= 1'b0;
      eq_p1  <= 1'b0;
      lt_p1  <= 1'b0;
      un_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        gt_p1 <= ord_p0[2];
        eq_p1 <= ord_p0[1];
        lt_p1 <= ord_p0[0];
        un_p1 <= nan_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign greater   = gt_p1;
  assign equal     = eq_p1;
  assign less      = lt_p1;
`ifdef FP_CMP_UNORDERED_EN
  assign unordered = un_p1;
`else
  logic unused_un;
  assign unused_un = un_p1;
`endif

endmodule

// File: tb/tb_fp_comparator.sv
// Scoreboard bench for fp_comparator: stimulus pushes expected flags, monitor pops on out_valid.
module tb_fp_comparator;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        in_valid;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic        out_valid;
  logic        greater;
  logic        equal;
  logic        less;
  logic        unordered_w;

  fp_comparator dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .out_valid (out_valid),
    .greater   (greater),
    .equal     (equal),
`ifdef FP_CMP_UNORDERED_EN
    .unordered (unordered_w),
`endif
    .less      (less)
  );

`ifndef FP_CMP_UNORDERED_EN
  assign unordered_w = 1'b0;
`endif

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [3:0] flags;  // {gt, eq, lt, unordered}
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got gt/eq/lt/un=%b, expected %b", name, act, req);
  endtask

  function automatic logic [3:0] cur_flags();
`ifdef FP_CMP_UNORDERED_EN
    return {greater, equal, less, unordered_w};
`else
    return {greater, equal, less, 1'b0};
`endif
  endfunction

  // Expected unordered bit only observable when the port exists.
  function automatic logic [3:0] mk(input logic [2:0] gel, input logic un);
`ifdef FP_CMP_UNORDERED_EN
    return {gel, un};
`else
    return {gel, 1'b0 & un};
`endif
  endfunction

  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] gel, input logic un);
    exp_t e;
    a_operand = a;
    b_operand = b;
    in_valid  = 1'b1;
    if (!RESET) begin
      e.name  = name;
      e.flags = mk(gel, un);
      exp_q.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  // Monitor
  always @(negedge CLK) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", cur_flags(), 4'bxxxx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk(e.name, cur_flags(), e.flags);
      end
    end
  end

  initial begin
    RESET     = 1'b1;
    in_valid  = 1'b0;
    a_operand = 32'd0;
    b_operand = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_state", {out_valid, greater, equal, less}, 4'b0000);
    RESET = 1'b0;
    idle();
    chk("after_release", {out_valid, greater, equal, less}, 4'b0000);

    issue("eq_10_10",      32'h41200000, 32'h41200000, 3'b010, 1'b0);
    issue("gt_10_5",       32'h41200000, 32'h40A00000, 3'b100, 1'b0);
    idle();
    chk("hold_after_idle", {out_valid, greater, equal, less}, 4'b0100);
    issue("lt_5_10",       32'h40A00000, 32'h41200000, 3'b001, 1'b0);
    issue("lt_n10_n5",     32'hC1200000, 32'hC0A00000, 3'b001, 1'b0);
    issue("gt_n1_n2",      32'hBF800000, 32'hC0000000, 3'b100, 1'b0);
    issue("eq_p0_n0",      32'h00000000, 32'h80000000, 3'b010, 1'b0);
    issue("nan_a",         32'h7FC00000, 32'h3F800000, 3'b000, 1'b1);
    issue("nan_b_snan",    32'h3F800000, 32'h7F800001, 3'b000, 1'b1);
    issue("gt_inf_max",    32'h7F800000, 32'h7F7FFFFF, 3'b100, 1'b0);
    issue("lt_ninf_nmax",  32'hFF800000, 32'hFF7FFFFF, 3'b001, 1'b0);
    issue("eq_inf_inf",    32'h7F800000, 32'h7F800000, 3'b010, 1'b0);
    issue("gt_denorm",     32'h00000002, 32'h00000001, 3'b100, 1'b0);
    issue("gt_denorm_n0",  32'h00000001, 32'h80000000, 3'b100, 1'b0);
    issue("lt_n0_denorm",  32'h80000000, 32'h00000001, 3'b001, 1'b0);
    issue("lt_ndenorm_0",  32'h80000001, 32'h00000000, 3'b001, 1'b0);
    issue("lt_neg_pos",    32'hBF800000, 32'h3F800000, 3'b001, 1'b0);
    idle();
    chk("hold_lt", {out_valid, greater, equal, less}, 4'b0001);

    // Back-to-back with reset on the second edge: second pair is discarded.
    issue("b2b_first_gt",  32'h40A00000, 32'h3F800000, 3'b100, 1'b0);
    RESET = 1'b1;
    issue("b2b_discarded", 32'h3F800000, 32'h40A00000, 3'b001, 1'b0);
    chk("reset_mid_stream", {out_valid, greater, equal, less}, 4'b0000);
    RESET = 1'b0;
    issue("b2b_third_eq",  32'hC0A00000, 32'hC0A00000, 3'b010, 1'b0);
    idle();
    chk("after_b2b", {out_valid, greater, equal, less}, 4'b0010);
    idle();

    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
